// File: rtl/tinsel_acc_pkg.sv
// Shared Tinsel NoC types for the forwarding/multicast accelerator: mesh sizes,
// NetAddr and Msg layouts, the fanout field position and the engine state type.
package tinsel_acc_pkg;

  localparam int TinselMeshXBits          = 2;
  localparam int TinselMeshYBits          = 2;
  localparam int TinselMailboxMeshXBits   = 2;
  localparam int TinselMailboxMeshYBits   = 2;
  localparam int TinselLogCoresPerMailbox = 2;
  localparam int TinselLogThreadsPerCore  = 4;
  localparam int TinselWordsPerMsg        = 4;
  localparam int TinselLogWordsPerMsg     = 2;

  localparam int FANOUT_BITS = 8;
  localparam int FANOUT_LSB  = 32;
  localparam int CT_BITS     = TinselLogCoresPerMailbox + TinselLogThreadsPerCore;

  typedef struct packed {
    logic [TinselMeshYBits-1:0]          board_y;
    logic [TinselMeshXBits-1:0]          board_x;
    logic [TinselMailboxMeshYBits-1:0]   tile_y;
    logic [TinselMailboxMeshXBits-1:0]   tile_x;
    logic [TinselLogCoresPerMailbox-1:0] core_id;
    logic [TinselLogThreadsPerCore-1:0]  thread_id;
  } NetAddr;

  localparam int NA_W = $bits(NetAddr);

  typedef struct packed {
    NetAddr                               dest;
    logic [TinselLogWordsPerMsg-1:0]      numWords;
    logic                                 isIdleToken;
    logic [TinselWordsPerMsg*32-1:0]      payload;
  } Msg;

  localparam int MSG_W = $bits(Msg);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } eng_state_t;

  // Offset the {core,thread} field by k modulo its width; tile/board fields never see a carry.
  function automatic NetAddr copy_dest(input NetAddr base, input logic [CT_BITS-1:0] k);
    NetAddr d;
    d = base;
    {d.core_id, d.thread_id} = {base.core_id, base.thread_id} + k;
    return d;
  endfunction

endpackage

// File: rtl/fwd_acc_fifo.sv
// Power-of-two FIFO with registered full/empty, state updated on the falling clock edge.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module fwd_acc_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_nxt;
  logic [AW-1:0]     rd_nxt;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_nxt  = wr_ptr + AW'(1);
  assign rd_nxt  = rd_ptr + AW'(1);
  assign head    = mem[rd_ptr];

  always_ff @(negedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          wr_ptr <= wr_nxt;
          empty  <= 1'b0;
          full   <= (wr_nxt == rd_ptr);
        end
        2'b01: begin
          rd_ptr <= rd_nxt;
          full   <= 1'b0;
          empty  <= (rd_nxt == wr_ptr);
        end
        2'b11: begin
          wr_ptr <= wr_nxt;
          rd_ptr <= rd_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fwd_multicast_accelerator.sv
// Tinsel NoC forwarding accelerator: forwards each message to the address in payload word 0.
// Define FWD_MULTICAST_ACC_MULTICAST_EN to emit F = word1[7:0] copies to consecutive threads.
module fwd_multicast_accelerator
  import tinsel_acc_pkg::*;
#(
  parameter int TILE_X    = 0,
  parameter int TILE_Y    = 0,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [TinselMeshXBits-1:0] board_x,
  input  logic [TinselMeshYBits-1:0] board_y,
  input  logic [MSG_W-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [MSG_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam logic [TinselLogWordsPerMsg-1:0] NUM_WORDS_M1 =
    TinselLogWordsPerMsg'(TinselWordsPerMsg - 1);

  logic [MSG_W-1:0] in_fifo_head;
  logic [MSG_W-1:0] out_fifo_head;
  Msg               in_head;
  Msg               out_msg;
  logic             in_full;
  logic             in_empty;
  logic             out_full;
  logic             out_empty;
  logic             in_push;
  logic             in_pop;
  logic             out_push;
  logic             load_hold;
  logic             k_inc;
  logic             emit_last;
  logic             active;
  eng_state_t       state;
  eng_state_t       state_nxt;
  logic [TinselWordsPerMsg*32-1:0] hold_p1;
  logic             unused_ok;

  assign unused_ok = ^{board_x, board_y, in_head.dest, in_head.numWords, TILE_X[0], TILE_Y[0]};

  // in_ready stays low until the first falling edge after reset is released.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) active <= 1'b0;
    else        active <= 1'b1;
  end

  assign in_ready  = active && !in_full;
  assign in_push   = in_valid && in_ready;
  assign in_head   = Msg'(in_fifo_head);
  assign out_valid = !out_empty;
  assign out_data  = out_valid ? out_fifo_head : '0;

  fwd_acc_fifo #(.DATA_W(MSG_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_push),
    .push_data (in_data),
    .pop       (in_pop),
    .head      (in_fifo_head),
    .full      (in_full),
    .empty     (in_empty)
  );

  fwd_acc_fifo #(.DATA_W(MSG_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (out_push),
    .push_data (out_msg),
    .pop       (out_ready),
    .head      (out_fifo_head),
    .full      (out_full),
    .empty     (out_empty)
  );

`ifdef FWD_MULTICAST_ACC_MULTICAST_EN
  logic [FANOUT_BITS-1:0] fanout;
  logic [FANOUT_BITS-1:0] k_p1;

  assign fanout    = hold_p1[FANOUT_LSB +: FANOUT_BITS];
  assign emit_last = (fanout == '0) || (k_p1 == fanout - 1'b1);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)         k_p1 <= '0;
    else if (load_hold) k_p1 <= '0;
    else if (k_inc)     k_p1 <= k_p1 + 1'b1;
  end

  always_comb begin
    out_msg             = '0;
    out_msg.dest        = copy_dest(NetAddr'(hold_p1[NA_W-1:0]), k_p1[CT_BITS-1:0]);
    out_msg.numWords    = NUM_WORDS_M1;
    out_msg.isIdleToken = 1'b0;
    out_msg.payload     = hold_p1;
  end
`else
  assign emit_last = 1'b1;

  always_comb begin
    out_msg             = '0;
    out_msg.dest        = NetAddr'(hold_p1[NA_W-1:0]);
    out_msg.numWords    = NUM_WORDS_M1;
    out_msg.isIdleToken = 1'b0;
    out_msg.payload     = hold_p1;
  end
`endif

  // Hold stage: payload of the message currently being emitted.
  always_ff @(negedge clk) begin
    if (load_hold) hold_p1 <= in_head.payload;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!in_empty && !in_head.isIdleToken) state_nxt = ST_EMIT;
      ST_EMIT: if (!out_full && emit_last && (in_empty || in_head.isIdleToken))
                 state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // On the last copy the next head is popped in the same cycle to sustain one message per cycle.
  always_comb begin
    in_pop    = 1'b0;
    out_push  = 1'b0;
    load_hold = 1'b0;
    k_inc     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!in_empty) begin
          in_pop    = 1'b1;
          load_hold = !in_head.isIdleToken;
        end
      end
      ST_EMIT: begin
        if (!out_full) begin
          out_push = 1'b1;
          if (emit_last) begin
            in_pop    = !in_empty;
            load_hold = !in_empty && !in_head.isIdleToken;
          end else begin
            k_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fwd_multicast_accelerator.sv
// Directed bench for fwd_multicast_accelerator; adapts to FWD_MULTICAST_ACC_MULTICAST_EN.
module tb_fwd_multicast_accelerator;
  import tinsel_acc_pkg::*;

  logic                       clk = 1'b1;
  logic                       rst_n = 1'b1;
  logic [TinselMeshXBits-1:0] board_x = '0;
  logic [TinselMeshYBits-1:0] board_y = '0;
  Msg                         in_data;
  logic                       in_valid;
  logic                       in_ready;
  Msg                         out_data;
  logic                       out_valid;
  logic                       out_ready;

  int checks = 0;
  int errors = 0;
  Msg cap_q[$];

  always #5 clk = ~clk;

  fwd_multicast_accelerator #(
    .TILE_X(0), .TILE_Y(0), .IN_DEPTH(4), .OUT_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .board_x   (board_x),
    .board_y   (board_y),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Output transfers complete at the next falling edge; record them half a cycle early.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) cap_q.push_back(out_data);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic Msg mk_msg(input logic [13:0] dst, input logic [7:0] fan,
                                input logic [31:0] tag, input logic idle);
    Msg m;
    m                 = '0;
    m.dest            = NetAddr'(14'h2AAA);
    m.numWords        = 2'd1;
    m.isIdleToken     = idle;
    m.payload[31:0]   = {18'd0, dst};
    m.payload[39:32]  = fan;
    m.payload[95:64]  = tag;
    return m;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input Msg m);
    int n;
    n = 0;
    in_data  = m;
    in_valid = 1'b1;
    @(posedge clk);
    while (!in_ready && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (!in_ready) check_eq("send_timeout", 64'(in_ready), 1);
    @(negedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx;
    int n;
    int n0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1 rst_n  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    @(posedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 0);
    check_eq("rst_out_valid", 64'(out_valid), 0);
    check_eq("rst_out_data", 64'(out_data[63:0]), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    check_eq("ready_before_edge", 64'(in_ready), 0);
    @(negedge clk);
    @(posedge clk);
    check_eq("ready_after_edge", 64'(in_ready), 1);
    @(negedge clk);
    #1;

    // Single forward with 2-edge latency
    cap_q.delete();
    in_data  = mk_msg(14'h063, 8'd1, 32'hA1, 1'b0);
    in_valid = 1'b1;
    @(posedge clk);
    check_eq("lat_accept", 64'(in_ready), 1);
    @(negedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    check_eq("lat_e0", 64'(out_valid), 0);
    @(negedge clk);
    @(posedge clk);
    check_eq("lat_e1", 64'(out_valid), 0);
    @(negedge clk);
    @(posedge clk);
    check_eq("lat_e2", 64'(out_valid), 1);
    tick(6);
    check_eq("fwd_count", 64'(cap_q.size()), 1);
    if (cap_q.size() >= 1) begin
      check_eq("fwd_dest", 64'(cap_q[0].dest), 64'h063);
      check_eq("fwd_numwords", 64'(cap_q[0].numWords), 3);
      check_eq("fwd_idle", 64'(cap_q[0].isIdleToken), 0);
      check_eq("fwd_tag", 64'(cap_q[0].payload[95:64]), 64'hA1);
    end

`ifdef FWD_MULTICAST_ACC_MULTICAST_EN
    // Fanout of 4 wrapping the 6-bit {core,thread} field, tile(1,1)
    begin
      logic [13:0] exp_d [4];
      exp_d = '{14'h17E, 14'h17F, 14'h140, 14'h141};
      cap_q.delete();
      send(mk_msg(14'h17E, 8'd4, 32'hB0, 1'b0));
      tick(10);
      check_eq("wrap_count", 64'(cap_q.size()), 4);
      for (int i = 0; i < 4; i++) begin
        if (i < cap_q.size()) begin
          check_eq($sformatf("wrap_dest%0d", i), 64'(cap_q[i].dest), 64'(exp_d[i]));
          check_eq($sformatf("wrap_tag%0d", i), 64'(cap_q[i].payload[95:64]), 64'hB0);
        end
      end
    end
    cap_q.delete();
    send(mk_msg(14'h063, 8'd0, 32'hB1, 1'b0));
    tick(8);
    check_eq("f0_count", 64'(cap_q.size()), 1);
`else
    // Without multicast, word 1 is ignored
    cap_q.delete();
    send(mk_msg(14'h17E, 8'd7, 32'hB0, 1'b0));
    tick(12);
    check_eq("nomc_count", 64'(cap_q.size()), 1);
    if (cap_q.size() >= 1) check_eq("nomc_dest", 64'(cap_q[0].dest), 64'h17E);
`endif

    // Idle token between two normal messages
    cap_q.delete();
    send(mk_msg(14'h063, 8'd1, 32'h20, 1'b0));
    send(mk_msg(14'h063, 8'd3, 32'h99, 1'b1));
    send(mk_msg(14'h063, 8'd1, 32'h21, 1'b0));
    tick(10);
    check_eq("idle_count", 64'(cap_q.size()), 2);
    if (cap_q.size() >= 2) begin
      check_eq("idle_tag0", 64'(cap_q[0].payload[95:64]), 64'h20);
      check_eq("idle_tag1", 64'(cap_q[1].payload[95:64]), 64'h21);
    end

    // Backpressure: 4 in input FIFO + 1 held + 4 in output FIFO
    cap_q.delete();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (idx < 12);
      in_data  = mk_msg(14'h063, 8'd1, 32'h100 + 32'(idx), 1'b0);
      @(posedge clk);
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_eq("bp_accepted", 64'(idx), 9);
    check_eq("bp_in_ready", 64'(in_ready), 0);
    check_eq("bp_out_valid", 64'(out_valid), 1);
    check_eq("bp_head_stable", 64'(out_data.payload[95:64]), 64'h100);
    out_ready = 1'b1;
    tick(20);
    check_eq("bp_count", 64'(cap_q.size()), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < cap_q.size())
        check_eq($sformatf("bp_tag%0d", i), 64'(cap_q[i].payload[95:64]), 64'(32'h100 + 32'(i)));
    end

`ifdef FWD_MULTICAST_ACC_MULTICAST_EN
    // Reset during copy 2 of a fanout of 5
    cap_q.delete();
    send(mk_msg(14'h063, 8'd5, 32'h50, 1'b0));
    n = 0;
    while (cap_q.size() < 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("mid_reached", 64'(cap_q.size()), 2);
    rst_n = 1'b0;
    #1;
    n0 = cap_q.size();
    check_eq("mid_rst_valid", 64'(out_valid), 0);
    check_eq("mid_rst_data", 64'(out_data[63:0]), 0);
    check_eq("mid_rst_ready", 64'(in_ready), 0);
    tick(2);
    rst_n = 1'b1;
    tick(15);
    check_eq("mid_no_resume", 64'(cap_q.size()), 64'(n0));
`endif

    // Reset with copies queued under backpressure
    cap_q.delete();
    out_ready = 1'b0;
    send(mk_msg(14'h063, 8'd5, 32'h60, 1'b0));
    tick(4);
    check_eq("rq_out_valid", 64'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check_eq("rq_rst_valid", 64'(out_valid), 0);
    check_eq("rq_rst_data", 64'(out_data[63:0]), 0);
    check_eq("rq_rst_ready", 64'(in_ready), 0);
    tick(2);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick(15);
    check_eq("rq_count", 64'(cap_q.size()), 0);
    check_eq("rq_ready_back", 64'(in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
